// File: rtl/parity_stream_unit.sv
// parity_stream_unit: streaming parity generator/checker with a valid/ready
// handshake, a per-frame longitudinal XOR (LRC) and a saturating error counter.
//
// Handshake: a word is accepted on in_valid && in_ready and transferred out on
// out_valid && out_ready; in_ready = !out_valid || out_ready, so the single
// output register sustains one word per cycle and a held word stays stable
// while out_ready is low.
//
// Optional build macro: PARITY_STICKY_ERR_EN adds the err_sticky output, a flag
// set by any accepted check-mode error and cleared only by clr_cnt or rst.
module parity_stream_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             odd_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_err,
  output logic             out_last,
  output logic [WIDTH-1:0] out_lrc,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
`ifdef PARITY_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_out_valid;
  logic [WIDTH:0]   r_out_data;
  logic             r_out_err;
  logic             r_out_last;
  logic [WIDTH-1:0] r_out_lrc;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_payload;
  logic             w_gen_bit;
  logic             w_chk_err;
  logic             w_word_err;
  logic [WIDTH-1:0] w_frame_lrc;

  assign w_ready     = !r_out_valid || out_ready;
  assign w_accept    = in_valid && w_ready;
  assign w_payload   = in_data[WIDTH:1];
  assign w_gen_bit   = (^w_payload) ^ odd_sel;
  assign w_chk_err   = (^in_data) ^ odd_sel;
  // Only check mode can flag an error; generate mode always reports clean.
  assign w_word_err  = mode && w_chk_err;
  assign w_frame_lrc = r_acc ^ w_payload;

  // Output register: loads on every ready cycle (zeros when nothing accepted),
  // holds while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_lrc   <= '0;
    end else if (w_ready) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_data <= mode ? in_data : {w_payload, w_gen_bit};
        r_out_err  <= w_word_err;
        r_out_last <= in_last;
        r_out_lrc  <= in_last ? w_frame_lrc : '0;
      end else begin
        r_out_data <= '0;
        r_out_err  <= 1'b0;
        r_out_last <= 1'b0;
        r_out_lrc  <= '0;
      end
    end
  end

  // Frame LRC accumulator: folds in each accepted payload, restarts after last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= in_last ? '0 : w_frame_lrc;
    end
  end

  // Error counter: counted at accept time, saturating; clr_cnt has priority.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_word_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

`ifdef PARITY_STICKY_ERR_EN
  logic r_sticky;

  // Sticky error flag: set by any accepted error, cleared by clr_cnt or rst.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_sticky <= 1'b0;
    end else if (w_accept && w_word_err) begin
      r_sticky <= 1'b1;
    end
  end

  assign err_sticky = r_sticky;
`endif

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign out_last  = r_out_last;
  assign out_lrc   = r_out_lrc;
  assign err_cnt   = r_err_cnt;

endmodule
